// File: rtl/light_pen_locator.sv
// Light-pen locator for an 8x8 LED matrix.
// Steps a single lit probe pixel through the matrix in raster order, samples
// the synchronized photodiode during each pixel's dwell, and reports the first
// hit pixel of the sweep together with the number of hit pixels.
module light_pen_locator #(
  parameter logic [15:0] DWELL      = 16'd2000,
  parameter logic [15:0] SETTLE     = 16'd500,
  parameter logic [7:0]  HIT_MIN    = 8'd8,
  parameter logic        PEN_ACTIVE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       pen_in,
  output logic       probe_en,
  output logic [2:0] probe_row,
  output logic [2:0] probe_col,
  output logic       busy,
  output logic [2:0] pos_x,
  output logic [2:0] pos_y,
  output logic       pos_valid,
  output logic       pen_present,
  output logic [6:0] hit_count
);

  typedef enum logic [1:0] {ST_IDLE, ST_PROBE, ST_REPORT} state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync2_q;
  logic        pen_s;
  logic [15:0] dwell_q, dwell_d;
  logic [7:0]  run_q, run_d;
  logic        pix_hit_q, pix_hit_d;
  logic [2:0]  row_q, row_d, col_q, col_d;
  logic [6:0]  sweep_hits_q, sweep_hits_d;
  logic        first_q, first_d;
  logic [2:0]  pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [2:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic        pos_valid_q, pos_valid_d;
  logic        pen_present_q, pen_present_d;
  logic [6:0]  hit_count_q, hit_count_d;

  logic        sampling, pixel_end, hit_now, clear_sweep;
  logic [7:0]  run_sample;
  logic [6:0]  hits_inc;

  // Two-flop synchronizer for the asynchronous photodiode input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pen_in;
      sync2_q <= sync1_q;
    end
  end

  assign pen_s     = (sync2_q == PEN_ACTIVE);
  assign sampling  = (dwell_q >= SETTLE);
  assign pixel_end = (dwell_q == DWELL - 16'd1);

  // Run length after this cycle's sample; saturates at HIT_MIN, zero in settle.
  assign run_sample = !sampling ? 8'd0 :
                      !pen_s    ? 8'd0 :
                      (run_q < HIT_MIN) ? run_q + 8'd1 : run_q;
  assign hit_now  = pix_hit_q | (run_sample >= HIT_MIN);
  assign hits_inc = sweep_hits_q + {6'd0, hit_now};

  // Next-state logic: sweep sequencing, hit detection and result capture.
  always_comb begin
    state_d       = state_q;
    dwell_d       = dwell_q;
    run_d         = run_q;
    pix_hit_d     = pix_hit_q;
    row_d         = row_q;
    col_d         = col_q;
    sweep_hits_d  = sweep_hits_q;
    first_d       = first_q;
    pend_x_d      = pend_x_q;
    pend_y_d      = pend_y_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    pos_valid_d   = 1'b0;
    pen_present_d = pen_present_q;
    hit_count_d   = hit_count_q;
    clear_sweep   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clear_sweep = 1'b1;
        if (enable) state_d = ST_PROBE;
      end
      ST_PROBE: begin
        if (!enable) begin
          // Abort: drop the partial sweep, keep last reported results.
          state_d     = ST_IDLE;
          clear_sweep = 1'b1;
        end else if (pixel_end) begin
          dwell_d      = 16'd0;
          run_d        = 8'd0;
          pix_hit_d    = 1'b0;
          sweep_hits_d = hits_inc;
          if (hit_now && !first_q) begin
            first_d  = 1'b1;
            pend_x_d = col_q;
            pend_y_d = row_q;
          end
          if (col_q == 3'd7) begin
            col_d = 3'd0;
            if (row_q == 3'd7) begin
              // Results are loaded so they are visible during the REPORT cycle.
              row_d         = 3'd0;
              state_d       = ST_REPORT;
              hit_count_d   = hits_inc;
              pen_present_d = (hits_inc != 7'd0);
              pos_valid_d   = (hits_inc != 7'd0);
              if (hits_inc != 7'd0) begin
                pos_x_d = pend_x_d;
                pos_y_d = pend_y_d;
              end
            end else begin
              row_d = row_q + 3'd1;
            end
          end else begin
            col_d = col_q + 3'd1;
          end
        end else begin
          dwell_d   = dwell_q + 16'd1;
          run_d     = run_sample;
          pix_hit_d = hit_now;
        end
      end
      ST_REPORT: begin
        clear_sweep = 1'b1;
        state_d     = enable ? ST_PROBE : ST_IDLE;
      end
      default: begin
        clear_sweep = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase

    if (clear_sweep) begin
      dwell_d      = 16'd0;
      run_d        = 8'd0;
      pix_hit_d    = 1'b0;
      row_d        = 3'd0;
      col_d        = 3'd0;
      sweep_hits_d = 7'd0;
      first_d      = 1'b0;
    end
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      dwell_q       <= 16'd0;
      run_q         <= 8'd0;
      pix_hit_q     <= 1'b0;
      row_q         <= 3'd0;
      col_q         <= 3'd0;
      sweep_hits_q  <= 7'd0;
      first_q       <= 1'b0;
      pend_x_q      <= 3'd0;
      pend_y_q      <= 3'd0;
      pos_x_q       <= 3'd0;
      pos_y_q       <= 3'd0;
      pos_valid_q   <= 1'b0;
      pen_present_q <= 1'b0;
      hit_count_q   <= 7'd0;
    end else begin
      state_q       <= state_d;
      dwell_q       <= dwell_d;
      run_q         <= run_d;
      pix_hit_q     <= pix_hit_d;
      row_q         <= row_d;
      col_q         <= col_d;
      sweep_hits_q  <= sweep_hits_d;
      first_q       <= first_d;
      pend_x_q      <= pend_x_d;
      pend_y_q      <= pend_y_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      pos_valid_q   <= pos_valid_d;
      pen_present_q <= pen_present_d;
      hit_count_q   <= hit_count_d;
    end
  end

  assign probe_en    = (state_q == ST_PROBE);
  assign busy        = (state_q != ST_IDLE);
  assign probe_row   = row_q;
  assign probe_col   = col_q;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign pos_valid   = pos_valid_q;
  assign pen_present = pen_present_q;
  assign hit_count   = hit_count_q;

endmodule

// File: tb/tb_light_pen_locator.sv
// Bench for light_pen_locator with DWELL=16, SETTLE=4, HIT_MIN=3.
// Each table row describes one sweep's pen pattern and its expected report.
module tb_light_pen_locator;

  localparam int DW  = 16;
  localparam int SW  = 1025;   // 64*DWELL probe cycles + 1 report cycle
  localparam int NV  = 7;

  logic       clk = 1'b0;
  logic       rst_n, enable, pen_in;
  logic       probe_en, busy, pos_valid, pen_present;
  logic [2:0] probe_row, probe_col, pos_x, pos_y;
  logic [6:0] hit_count;

  light_pen_locator #(
    .DWELL(16'd16), .SETTLE(16'd4), .HIT_MIN(8'd3), .PEN_ACTIVE(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .pen_in(pen_in),
    .probe_en(probe_en), .probe_row(probe_row), .probe_col(probe_col),
    .busy(busy), .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid),
    .pen_present(pen_present), .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  // Pen pattern per sweep: full-dwell pixel mask plus up to four dwell windows
  // (windows give the wanted synchronized pen level per dwell cycle).
  typedef struct packed {
    logic [63:0]     mask;
    logic [3:0]      wen;
    logic [3:0][5:0] wpix;
    logic [3:0][3:0] wlo;
    logic [3:0][3:0] whi;
    logic [6:0]      e_cnt;
    logic            e_pres;
    logic            e_pv;
    logic [2:0]      e_x;
    logic [2:0]      e_y;
  } vec_t;

  typedef struct packed {
    logic [6:0] cnt;
    logic       pres;
    logic       pv;
    logic [2:0] x;
    logic [2:0] y;
  } exp_t;

  vec_t vec[NV];
  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_exp(input int s, input int cnt, input int pres, input int pv,
                         input int x, input int y);
    vec[s].e_cnt  = 7'(cnt);
    vec[s].e_pres = 1'(pres);
    vec[s].e_pv   = 1'(pv);
    vec[s].e_x    = 3'(x);
    vec[s].e_y    = 3'(y);
  endtask

  task automatic set_win(input int s, input int w, input int p, input int lo, input int hi);
    vec[s].wen[w]  = 1'b1;
    vec[s].wpix[w] = 6'(p);
    vec[s].wlo[w]  = 4'(lo);
    vec[s].whi[w]  = 4'(hi);
  endtask

  // Wanted synchronized pen level at global cycle g (cycle 0 = first probe cycle).
  function automatic logic pen_want(input int g);
    int s, j, p, d;
    s = g / SW;
    j = g % SW;
    if (s >= NV || j >= 64 * DW) return 1'b0;
    p = j / DW;
    d = j % DW;
    if (vec[s].mask[p]) return 1'b1;
    for (int w = 0; w < 4; w++)
      if (vec[s].wen[w] && int'(vec[s].wpix[w]) == p &&
          d >= int'(vec[s].wlo[w]) && d <= int'(vec[s].whi[w]))
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_probe_en"},    probe_en,    0);
    check({tag, "_busy"},        busy,        0);
    check({tag, "_probe_row"},   probe_row,   0);
    check({tag, "_probe_col"},   probe_col,   0);
    check({tag, "_pos_x"},       pos_x,       0);
    check({tag, "_pos_y"},       pos_y,       0);
    check({tag, "_pos_valid"},   pos_valid,   0);
    check({tag, "_pen_present"}, pen_present, 0);
    check({tag, "_hit_count"},   hit_count,   0);
  endtask

  initial begin
    exp_t e, a;
    int   j, s;
    logic pv_spur;

    // ---- sweep table ----
    for (int i = 0; i < NV; i++) vec[i] = '0;
    set_exp(0, 0, 0, 0, 0, 0);                     // no pen
    vec[1].mask[3*8+5] = 1'b1;                     // single hit at row3,col5
    set_exp(1, 1, 1, 1, 5, 3);
    set_win(2, 0, 2*8+2, 0, 3);                    // settle-only activity
    set_win(2, 1, 4*8+4, 6, 7);                    // 2 samples, below HIT_MIN
    set_exp(2, 0, 0, 0, 5, 3);
    vec[3].mask[1*8+2] = 1'b1;                     // two hits, first wins
    vec[3].mask[4*8+6] = 1'b1;
    set_exp(3, 2, 1, 1, 2, 1);
    set_win(4, 0, 10, 2, 5);                       // run crossing settle boundary
    set_win(4, 1, 11, 6, 7);                       // broken run 2+2
    set_win(4, 2, 11, 9, 10);
    set_exp(4, 0, 0, 0, 2, 1);
    set_win(5, 0, 63, 12, 14);                     // exactly HIT_MIN on last pixel
    set_exp(5, 1, 1, 1, 7, 7);
    vec[6].mask = '1;                              // every pixel hit
    set_exp(6, 64, 1, 1, 0, 0);

    // ---- reset with enable high and pen toggling ----
    rst_n  = 1'b0;
    enable = 1'b1;
    pen_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      pen_in = ~pen_in;
    end
    @(negedge clk);
    check_all_zero("reset");
    $display("reset held: outputs checked");
    pen_in = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;
    check("release_probe_en", probe_en, 1);

    // ---- table-driven sweeps, enable held high ----
    pv_spur = 1'b0;
    for (int k = 0; k < NV * SW; k++) begin
      s = k / SW;
      j = k % SW;
      pen_in = pen_want(k + 2);
      if (j == 0) begin
        e = '{cnt: vec[s].e_cnt, pres: vec[s].e_pres, pv: vec[s].e_pv,
              x: vec[s].e_x, y: vec[s].e_y};
        sbq.push_back(e);
      end
      if (j < 64 * DW && (j % DW) == 0) begin
        check("probe_en", probe_en, 1);
        check("probe_row", probe_row, (j / DW) / 8);
        check("probe_col", probe_col, (j / DW) % 8);
      end
      if (j != 64 * DW && pos_valid) pv_spur = 1'b1;
      if (j == 64 * DW - 1) begin
        check("pos_valid_outside_report", pv_spur, 0);
        pv_spur = 1'b0;
      end
      if (j == 64 * DW) check("report_timing", busy && !probe_en, 1);
      else if (busy && !probe_en) check("report_early", j, 64 * DW);
      if (busy && !probe_en) begin
        if (sbq.size() == 0) begin
          check("scoreboard_underflow", 1, 0);
        end else begin
          e = sbq.pop_front();
          a = '{cnt: hit_count, pres: pen_present, pv: pos_valid, x: pos_x, y: pos_y};
          check("hit_count",   a.cnt,  e.cnt);
          check("pen_present", a.pres, e.pres);
          check("pos_valid",   a.pv,   e.pv);
          check("pos_x",       a.x,    e.x);
          check("pos_y",       a.y,    e.y);
          $display("sweep %0d report: hits=%0d present=%0d valid=%0d x=%0d y=%0d",
                   s, a.cnt, a.pres, a.pv, a.x, a.y);
        end
      end
      @(posedge clk);
      #1;
    end

    // ---- abort while probing pixel 20 ----
    pen_in = 1'b0;
    for (int c = 0; c < 20 * DW + 5; c++) begin
      if (pos_valid) pv_spur = 1'b1;
      @(posedge clk);
      #1;
    end
    check("abort_pre_row", probe_row, 2);
    check("abort_pre_col", probe_col, 4);
    enable = 1'b0;
    @(posedge clk);
    #1;
    check("abort_probe_en",    probe_en,    0);
    check("abort_busy",        busy,        0);
    check("abort_pos_valid",   pos_valid,   0);
    check("abort_probe_row",   probe_row,   0);
    check("abort_probe_col",   probe_col,   0);
    check("abort_pos_x",       pos_x,       0);
    check("abort_pos_y",       pos_y,       0);
    check("abort_hit_count",   hit_count,   64);
    check("abort_pen_present", pen_present, 1);
    for (int c = 0; c < 5; c++) begin
      if (pos_valid || busy) pv_spur = 1'b1;
      @(posedge clk);
      #1;
    end
    check("abort_quiet", pv_spur, 0);
    $display("abort: idle with results retained");
    enable = 1'b1;
    @(posedge clk);
    #1;
    check("restart_probe_en", probe_en,  1);
    check("restart_busy",     busy,      1);
    check("restart_row",      probe_row, 0);
    check("restart_col",      probe_col, 0);
    repeat (2 * DW) @(posedge clk);
    #1;
    check("restart_adv_col", probe_col, 2);

    // ---- asynchronous reset mid-sweep ----
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    $display("async reset mid-sweep: outputs checked");
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_busy",     busy,     0);
    check("post_reset_probe_en", probe_en, 0);
    check("scoreboard_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
